i2c_bus_bridge: RTL and testbench

//  Memory-mapped front end that sits upstream of the I2C master and drives it.
//  The CPU programs device address, byte mask, direction and TX data, then sets START.
//  The bridge releases the master from reset, tracks its busy flag through one transfer,

---
 rtl/i2c_bus_bridge.sv | 187 ++++++++++++++++++
 tb/tb_i2c_bus_bridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_bridge.sv
// CPU-facing register front end for an I2C master. It holds the master in reset while idle,
// launches one transfer per START, follows the master's busy flag and captures masked RX data.
module i2c_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        m_reset,
    output logic [3:0]  m_mask,
    output logic [6:0]  m_device_addr,
    output logic [31:0] m_data_in,
    output logic        m_write,
    input  logic [31:0] m_data_out,
    input  logic        m_busy
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    devaddr_q, devaddr_d;
    logic [31:0]   txdata_q, txdata_d;
    logic [31:0]   rxdata_q, rxdata_d;
    logic [3:0]    ctrl_mask_q, ctrl_mask_d;
    logic          ctrl_write_q, ctrl_write_d;
    logic          done_q, done_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_mask_q, err_mask_d;
    logic          m_reset_q, m_reset_d;
    logic [3:0]    m_mask_q, m_mask_d;
    logic [6:0]    m_device_addr_q, m_device_addr_d;
    logic [31:0]   m_data_in_q, m_data_in_d;
    logic          m_write_q, m_write_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic [31:0]   rx_masked;
    logic [31:0]   status;
    logic          wr_en, rd_en, start_req;

    // Bytes not selected by the transfer mask read back as zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rx_mask
        assign rx_masked[gi*8 +: 8] = m_data_out[gi*8 +: 8] & {8{m_mask_q[gi]}};
    end

    assign status    = {23'b0, ctrl_write_q, ctrl_mask_q, err_mask_q, err_timeout_q,
                        done_q, (state_q != IDLE)};
    assign wr_en     = req_valid && req_write;
    assign rd_en     = req_valid && !req_write;
    assign start_req = wr_en && (req_addr == 2'd0) && req_wdata[0];

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        devaddr_d       = devaddr_q;
        txdata_d        = txdata_q;
        rxdata_d        = rxdata_q;
        ctrl_mask_d     = ctrl_mask_q;
        ctrl_write_d    = ctrl_write_q;
        done_d          = done_q;
        err_timeout_d   = err_timeout_q;
        err_mask_d      = err_mask_q;
        m_mask_d        = m_mask_q;
        m_device_addr_d = m_device_addr_q;
        m_data_in_d     = m_data_in_q;
        m_write_d       = m_write_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = resp_rdata_q;

        if (rd_en) begin
            resp_valid_d = 1'b1;
            case (req_addr)
                2'd0:    resp_rdata_d = status;
                2'd1:    resp_rdata_d = {25'b0, devaddr_q};
                2'd2:    resp_rdata_d = txdata_q;
                default: resp_rdata_d = rxdata_q;
            endcase
        end

        if (wr_en) begin
            case (req_addr)
                2'd0: begin
                    ctrl_mask_d  = req_wdata[7:4];
                    ctrl_write_d = req_wdata[1];
                end
                2'd1:    devaddr_d = req_wdata[6:0];
                2'd2:    txdata_d  = req_wdata;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    if (req_wdata[7:4] != 4'd0) begin
                        m_mask_d        = req_wdata[7:4];
                        m_write_d       = req_wdata[1];
                        m_device_addr_d = devaddr_q;
                        m_data_in_d     = txdata_q;
                        done_d          = 1'b0;
                        err_timeout_d   = 1'b0;
                        err_mask_d      = 1'b0;
                        timer_d         = '0;
                        state_d         = LAUNCH;
                    end else begin
                        err_mask_d = 1'b1;
                    end
                end
            end
            LAUNCH, RUN: begin
                timer_d = timer_q + TW'(1);
                // Timeout wins over a busy edge seen in the same cycle.
                if (timer_q == TIMER_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (state_q == LAUNCH && m_busy) begin
                    state_d = RUN;
                end else if (state_q == RUN && !m_busy) begin
                    state_d = DONE;
                end
            end
            default: begin
                if (!m_write_q) rxdata_d = rx_masked;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase

        m_reset_d = !((state_d == LAUNCH) || (state_d == RUN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            devaddr_q       <= '0;
            txdata_q        <= '0;
            rxdata_q        <= '0;
            ctrl_mask_q     <= '0;
            ctrl_write_q    <= 1'b0;
            done_q          <= 1'b0;
            err_timeout_q   <= 1'b0;
            err_mask_q      <= 1'b0;
            m_reset_q       <= 1'b1;
            m_mask_q        <= '0;
            m_device_addr_q <= '0;
            m_data_in_q     <= '0;
            m_write_q       <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            devaddr_q       <= devaddr_d;
            txdata_q        <= txdata_d;
            rxdata_q        <= rxdata_d;
            ctrl_mask_q     <= ctrl_mask_d;
            ctrl_write_q    <= ctrl_write_d;
            done_q          <= done_d;
            err_timeout_q   <= err_timeout_d;
            err_mask_q      <= err_mask_d;
            m_reset_q       <= m_reset_d;
            m_mask_q        <= m_mask_d;
            m_device_addr_q <= m_device_addr_d;
            m_data_in_q     <= m_data_in_d;
            m_write_q       <= m_write_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign m_reset       = m_reset_q;
    assign m_mask        = m_mask_q;
    assign m_device_addr = m_device_addr_q;
    assign m_data_in     = m_data_in_q;
    assign m_write       = m_write_q;
endmodule

// File: tb/tb_i2c_bus_bridge.sv
// Directed bench for i2c_bus_bridge: register access, write/read transfers, mask error,
// timeout, mid-transfer CPU activity and asynchronous reset.
module tb_i2c_bus_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        m_reset;
    logic [3:0]  m_mask;
    logic [6:0]  m_device_addr;
    logic [31:0] m_data_in;
    logic        m_write;
    logic [31:0] m_data_out;
    logic        m_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2c_bus_bridge #(.TIMEOUT_CYCLES(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .m_reset       (m_reset),
        .m_mask        (m_mask),
        .m_device_addr (m_device_addr),
        .m_data_in     (m_data_in),
        .m_write       (m_write),
        .m_data_out    (m_data_out),
        .m_busy        (m_busy)
    );

    // Bus helpers return #1 after the accepting edge, when a read response is visible.
    task automatic cpu_write(input logic [1:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] addr, output logic [31:0] data, output logic vld);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        data = resp_rdata;
        vld  = resp_valid;
    endtask

    // Master model: raise busy after a short delay, hold it, drop it, let the bridge settle.
    task automatic run_busy(input int cycles);
        repeat (2) @(posedge clk);
        #1 m_busy = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 m_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic v;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = '0;
        m_data_out = '0; m_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++;
        if ({m_reset, m_mask, m_device_addr, m_data_in, m_write, resp_valid, resp_rdata} !==
            {1'b1, 4'h0, 7'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: m_reset=%b m_mask=%h m_dev=%h m_data_in=%h m_write=%b resp_valid=%b resp_rdata=%h, required 1/0/0/0/0/0/0",
                     m_reset, m_mask, m_device_addr, m_data_in, m_write, resp_valid, resp_rdata);
        end
        cpu_read(2'd0, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: valid=%b data=%h, required valid=1 data=00000000", v, d);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b0 || m_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_pulse: resp_valid=%b m_reset=%b, required 0 and 1", resp_valid, m_reset);
        end
        $display("test_reset done");
    endtask

    task automatic test_write_transfer;
        logic [31:0] d; logic v;
        cpu_write(2'd1, 32'h0000_003C);
        cpu_write(2'd2, 32'hA1B2_C3D4);
        cpu_write(2'd0, 32'h0000_00F3);
        n_checks++;
        if ({m_reset, m_mask, m_write, m_device_addr, m_data_in} !==
            {1'b0, 4'hF, 1'b1, 7'h3C, 32'hA1B2_C3D4}) begin
            n_fail++;
            $display("FAIL wr_launch: m_reset=%b m_mask=%h m_write=%b m_dev=%h m_data_in=%h, required 0/f/1/3c/a1b2c3d4",
                     m_reset, m_mask, m_write, m_device_addr, m_data_in);
        end
        run_busy(20);
        n_checks++;
        if (m_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_m_reset: m_reset=%b, required 1", m_reset);
        end
        cpu_read(2'd0, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h0000_01F2) begin
            n_fail++;
            $display("FAIL wr_status: valid=%b data=%h, required valid=1 data=000001f2", v, d);
        end
        cpu_read(2'd3, d, v);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_rxdata: data=%h, required 00000000", d);
        end
        $display("test_write_transfer done");
    endtask

    task automatic test_read_transfer;
        logic [31:0] d; logic v;
        m_data_out = 32'hFFEE_DDCC;
        cpu_write(2'd0, 32'h0000_0061);
        n_checks++;
        if (m_reset !== 1'b0 || m_mask !== 4'h6 || m_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_launch: m_reset=%b m_mask=%h m_write=%b, required 0/6/0", m_reset, m_mask, m_write);
        end
        run_busy(10);
        cpu_read(2'd3, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h00EE_DD00) begin
            n_fail++;
            $display("FAIL rd_rxdata: valid=%b data=%h, required valid=1 data=00eedd00", v, d);
        end
        cpu_read(2'd0, d, v);
        n_checks++;
        if (d !== 32'h0000_0062) begin
            n_fail++;
            $display("FAIL rd_status: data=%h, required 00000062", d);
        end
        $display("test_read_transfer done");
    endtask

    task automatic test_back_to_back;
        cpu_write(2'd3, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_003C) begin
            n_fail++;
            $display("FAIL b2b_devaddr: valid=%b data=%h, required valid=1 data=0000003c", resp_valid, resp_rdata);
        end
        req_addr = 2'd2;
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hA1B2_C3D4) begin
            n_fail++;
            $display("FAIL b2b_txdata: valid=%b data=%h, required valid=1 data=a1b2c3d4", resp_valid, resp_rdata);
        end
        req_addr = 2'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h00EE_DD00) begin
            n_fail++;
            $display("FAIL b2b_rxdata_ro: valid=%b data=%h, required valid=1 data=00eedd00", resp_valid, resp_rdata);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: resp_valid=%b, required 0", resp_valid);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_mask_error;
        logic [31:0] d; logic v;
        logic saw_release;
        saw_release = 1'b0;
        cpu_write(2'd0, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            if (m_reset !== 1'b1) saw_release = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (saw_release !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_m_reset: m_reset dropped=%b, required 0", saw_release);
        end
        cpu_read(2'd0, d, v);
        n_checks++;
        if (d[0] !== 1'b0 || d[3] !== 1'b1 || d[7:4] !== 4'h0) begin
            n_fail++;
            $display("FAIL mask_status: busy=%b err_mask=%b mask=%h, required 0/1/0", d[0], d[3], d[7:4]);
        end
        $display("test_mask_error done");
    endtask

    task automatic test_timeout;
        logic [31:0] d; logic v;
        m_data_out = 32'h1234_5678;
        m_busy = 1'b0;
        cpu_write(2'd0, 32'h0000_0011);
        repeat (63) @(posedge clk);
        #1;
        n_checks++;
        if (m_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL to_before: m_reset=%b after 63 cycles, required 0", m_reset);
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL to_at64: m_reset=%b after 64 cycles, required 1", m_reset);
        end
        cpu_read(2'd0, d, v);
        n_checks++;
        if (d !== 32'h0000_0014) begin
            n_fail++;
            $display("FAIL to_status: data=%h, required 00000014", d);
        end
        cpu_read(2'd3, d, v);
        n_checks++;
        if (d !== 32'h00EE_DD00) begin
            n_fail++;
            $display("FAIL to_rxdata: data=%h, required 00eedd00", d);
        end
        $display("test_timeout done");
    endtask

    task automatic test_run_interference;
        logic [31:0] d; logic v;
        cpu_write(2'd2, 32'h55AA_55AA);
        cpu_write(2'd0, 32'h0000_00F3);
        repeat (2) @(posedge clk);
        #1 m_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cpu_write(2'd2, 32'h0000_0000);
        n_checks++;
        if (m_data_in !== 32'h55AA_55AA) begin
            n_fail++;
            $display("FAIL run_txdata: m_data_in=%h, required 55aa55aa", m_data_in);
        end
        cpu_write(2'd0, 32'h0000_0021);
        cpu_read(2'd0, d, v);
        n_checks++;
        if (d !== 32'h0000_0021 || m_mask !== 4'hF || m_write !== 1'b1 || m_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL run_start_ignored: status=%h m_mask=%h m_write=%b m_reset=%b, required 00000021/f/1/0",
                     d, m_mask, m_write, m_reset);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (m_reset !== 1'b1 || m_data_in !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: m_reset=%b m_data_in=%h, required 1/00000000", m_reset, m_data_in);
        end
        @(posedge clk); #1;
        reset = 1'b0; m_busy = 1'b0;
        cpu_read(2'd0, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_status: valid=%b data=%h, required valid=1 data=00000000", v, d);
        end
        $display("test_run_interference done");
    endtask

    initial begin
        test_reset();
        test_write_transfer();
        test_read_transfer();
        test_back_to_back();
        test_mask_error();
        test_timeout();
        test_run_interference();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
